led_bank_arbiter: RTL and testbench
===================================

// Module: led_bank_arbiter
// PURPOSE
//  Time-shares the 12-LED output bank between N_REQ pattern sources (debug status, heartbeat, error code, ...).
//  Round-robin req/gnt arbiter with a prescaled slice timer.
//  Owner holds the bank for at least HOLD_TICKS prescaler ticks, then yields if another source is waiting.
//  Sits between the pattern generators and the top-level led pins, on the BUFGCTRL-buffered fabric clock.
// PARAMETERS
//  N_REQ      4   number of requesters (>=1)
//  LED_W      12  LED bank width
//  DIV_W      23  prescaler width; tick period = 2**DIV_W clocks
//  HOLD_TICKS 4   minimum ownership slice in ticks (>=1); slice counter width = $clog2(HOLD_TICKS+1)
// PORTS
//  clk_i   in   1            fabric clock (buffered)
//  rst_ni  in   1            asynchronous active-low reset
//  req_i   in   N_REQ        per-source request, level; held while the source wants the bank
//  pat_i   in   N_REQ*LED_W  per-source pattern; source s at [s*LED_W +: LED_W]
//  gnt_o   out  N_REQ        registered one-hot grant; all-zero when no owner
//  led_o   out  LED_W        registered LED drive
//  tick_o  out  1            one-cycle prescaler tick, exported for pattern generators
//  busy_o  out  1            1 while state==OWN
// BEHAVIOUR
//  Reset (async, rst_ni=0): state=IDLE, gnt_o=0, led_o=0, tick_o=0, busy_o=0, prescaler=0, slice=0, last=N_REQ-1.
//  No clocks are required for outputs to clear.
//  Prescaler: DIV_W-bit free-running up-counter. tick_o=1 for the cycle after the counter wraps all-ones->0.
//  First tick_o is at clock edge 2**DIV_W after reset release.
//  FSM states:
//   IDLE: gnt_o=0, led_o=0. If |req_i -> ARB.
//   ARB (exactly 1 cycle): winner = first set req_i scanning last+1, last+2, ... mod N_REQ.
//     If req_i==0 on this cycle (request withdrawn) -> IDLE.
//     Else at the edge: gnt_o=onehot(winner), last=winner, slice=0 -> OWN.
//   OWN: led_o <= pat_i[owner] every cycle, so one-cycle latency and live tracking of pattern changes.
//     slice increments on tick_o and saturates at HOLD_TICKS.
//  OWN exit rules, evaluated each cycle in priority order:
//   1. req_i[owner]==0 -> gnt_o=0, led_o=0 next edge; -> ARB if any other req else IDLE.
//   2. slice==HOLD_TICKS and any other req_i set -> gnt_o=0, led_o=0 next edge; -> ARB (preemption).
//   3. otherwise stay OWN. The owner keeps the bank indefinitely while no one else requests.
//  Latency: req rising, sampled at edge k in IDLE -> gnt_o at edge k+1 -> pattern on led_o at edge k+2.
//  Handover always inserts one ARB cycle with gnt_o=0 and led_o=0 (break-before-make). No two grants ever overlap.
//  Simultaneous events:
//   - drop and slice expiry on the same cycle: rule 1 wins.
//   - tick_o on the cycle slice reaches HOLD_TICKS-1: expiry seen next cycle.
//   - request withdrawn during ARB: skipped by the scan.
//  N_REQ==1: never preempted; rule 2 is unreachable.
//  Fairness: a requester waits at most (N_REQ-1) slices plus (N_REQ-1) ARB cycles.
//  Reset mid-OWN: grant and leds clear immediately; last returns to N_REQ-1, so source 0 wins first after reset.
//  Unknown/illegal state encoding -> IDLE.
// STRUCTURE
//  led_arb_pkg: state enum {IDLE, ARB, OWN}; LED_W_DEFAULT=12; function rr_pick(req, last) returning index+valid.
//  Sub-module led_tick_gen (prescaler, DIV_W param, outputs tick_o), reused by pattern generators.
//  The arbiter FSM, slice counter and output mux live in this module.
// TESTING (bench uses DIV_W=4 so ticks occur every 16 clocks; HOLD_TICKS=2, N_REQ=4)
//  T1 reset: assert rst_ni=0 mid-OWN between edges -> gnt_o=0, led_o=0, busy_o=0 with no clock edge.
//     After release, first tick_o is at edge 16.
//  T2 single request: req_i=4'b0100, pat2=12'hA5A -> gnt_o=4'b0100 at edge k+1, led_o=12'hA5A at k+2.
//     Holds indefinitely with no other requests.
//  T3 preemption: owner 2 plus req_i[0] raised -> handover after the 2nd tick following grant.
//     One cycle of gnt_o=0 and led_o=0, then gnt_o=4'b0001.
//  T4 round-robin: req_i=4'b1111 held -> grant order 0,1,2,3,0.
//     Each slice lasts 2 ticks; every handover has a 1-cycle gap.
//  T5 drop vs expiry: owner drops req on the same cycle the slice expires, other requests pending
//     -> rule 1 (drop) taken. last=owner; the next winner is the next set request after it.
//  T6 live pattern: change pat_i[owner] from 12'h00F to 12'hF00 while OWN -> led_o follows one cycle later.
//     Assertion on every cycle: $onehot0(gnt_o).

Source files
------------

// File: rtl/led_arb_pkg.sv
// led_arb_pkg: shared types, FSM encodings and the round-robin picker used
// by the LED bank arbiter.
//   LED_W_DEFAULT : default LED bank width
//   state_t/ST_*  : arbiter FSM encodings (2-bit, legacy-compatible constants)
//   rr_pick()     : round-robin scan starting just after the last owner
package led_arb_pkg;

  localparam int LED_W_DEFAULT = 12;

  // The picker works on a fixed 32-entry request vector so one function
  // serves every N_REQ up to 32; unused upper requests are tied low.
  localparam int RR_MAX   = 32;
  localparam int RR_IDX_W = 5;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_ARB  = 2'd1;
  localparam state_t ST_OWN  = 2'd2;

  typedef struct packed {
    logic                valid;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  // First set request scanning last+1, last+2, ... modulo n (n = live requesters).
  function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0]   req,
                                       input logic [RR_IDX_W-1:0] last,
                                       input logic [RR_IDX_W:0]   n);
    rr_pick_t          res;
    logic [RR_IDX_W:0] cand;
    res.valid = 1'b0;
    res.idx   = '0;
    for (int i = 1; i <= RR_MAX; i++) begin
      cand = {1'b0, last} + 6'(i);
      if (cand >= n) begin
        cand = cand - n;
      end else begin
        cand = cand;
      end
      if ((i <= int'(n)) && !res.valid && req[cand[RR_IDX_W-1:0]]) begin
        res.valid = 1'b1;
        res.idx   = cand[RR_IDX_W-1:0];
      end else begin
        res.valid = res.valid;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/led_bank_arbiter_if.sv
// led_bank_arbiter_if: bundle between the pattern sources and the arbiter.
//   req_i  : per-source level request
//   pat_i  : per-source pattern, source s at [s*LED_W +: LED_W]
//   gnt_o  : registered one-hot grant (zero when nobody owns the bank)
//   led_o  : registered LED drive
//   tick_o : one-cycle prescaler tick for the pattern generators
//   busy_o : high while the bank is owned
// master = pattern-source side, slave = arbiter side.
interface led_bank_arbiter_if
  import led_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int LED_W = LED_W_DEFAULT
) ();
  logic [N_REQ-1:0]       req_i;
  logic [N_REQ*LED_W-1:0] pat_i;
  logic [N_REQ-1:0]       gnt_o;
  logic [LED_W-1:0]       led_o;
  logic                   tick_o;
  logic                   busy_o;

  modport master (output req_i, output pat_i,
                  input  gnt_o, input  led_o, input tick_o, input busy_o);
  modport slave  (input  req_i, input  pat_i,
                  output gnt_o, output led_o, output tick_o, output busy_o);
endinterface

// File: rtl/led_bank_arbiter_chk.sv
// led_bank_arbiter_chk: property checker for the LED bank arbiter.
//   clk_i, rst_ni : arbiter clock and reset
//   gnt           : arbiter grant vector
//   busy          : arbiter busy flag
module led_bank_arbiter_chk #(
  parameter int N_REQ = 4
) (
  input logic             clk_i,
  input logic             rst_ni,
  input logic [N_REQ-1:0] gnt,
  input logic             busy
);
  a_gnt_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(gnt))
    else $error("grant vector has more than one bit set");

  a_busy_gnt: assert property (@(posedge clk_i) disable iff (!rst_ni) busy == (|gnt))
    else $error("busy disagrees with grant");
endmodule

// File: rtl/led_tick_gen.sv
// led_tick_gen: free-running DIV_W-bit prescaler.
//   clk_i  : fabric clock
//   rst_ni : asynchronous active-low reset
//   tick_o : high for the one cycle after the counter wraps all-ones -> 0,
//            so the first tick follows clock edge 2**DIV_W after reset release
module led_tick_gen #(
  parameter int DIV_W = 23
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);
  logic [DIV_W-1:0] cnt_r;
  logic             tick_r;

  // Prescaler count and registered wrap tick.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_r + DIV_W'(1'b1);
      tick_r <= &cnt_r;
    end
  end

  assign tick_o = tick_r;
endmodule

// File: rtl/led_bank_arbiter.sv
// led_bank_arbiter: time-shares the LED bank between N_REQ pattern sources.
// Round-robin arbiter with a prescaled ownership slice: the owner keeps the
// bank for at least HOLD_TICKS ticks and then yields if someone else waits.
// Every handover passes through one ARB cycle with grant and LEDs cleared.
//   clk_i  : fabric clock (buffered)
//   rst_ni : asynchronous active-low reset, clears outputs without a clock
//   bus    : led_bank_arbiter_if slave (req_i, pat_i in; gnt_o, led_o,
//            tick_o, busy_o out)
module led_bank_arbiter
  import led_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int LED_W      = LED_W_DEFAULT,
  parameter int DIV_W      = 23,
  parameter int HOLD_TICKS = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  led_bank_arbiter_if.slave   bus
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int SL_W  = $clog2(HOLD_TICKS + 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1'b1);
  localparam logic [SL_W-1:0]  SLICE_MAX = SL_W'(HOLD_TICKS);

  state_t              state_r, state_nxt_s;
  logic [N_REQ-1:0]    gnt_r, gnt_nxt_s;
  logic [LED_W-1:0]    led_r, led_nxt_s;
  logic                busy_r, busy_nxt_s;
  logic [IDX_W-1:0]    last_r, last_nxt_s;
  logic [SL_W-1:0]     slice_r, slice_nxt_s;

  logic                tick_s;
  logic [RR_MAX-1:0]   req_ext_s;
  logic [RR_IDX_W-1:0] last_ext_s;
  rr_pick_t            pick_s;
  logic                pick_ok_s;
  logic                owner_req_s;
  logic                others_s;
  logic [LED_W-1:0]    owner_pat_s;

  led_tick_gen #(.DIV_W(DIV_W)) u_tick_gen (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .tick_o (tick_s)
  );

  // Owner view (last winner is the current owner) and round-robin pick.
  always_comb begin
    req_ext_s                 = '0;
    req_ext_s[N_REQ-1:0]      = bus.req_i;
    last_ext_s                = '0;
    last_ext_s[IDX_W-1:0]     = last_r;
    pick_s                    = rr_pick(req_ext_s, last_ext_s, 6'(N_REQ));
    pick_ok_s   = pick_s.valid && ({1'b0, pick_s.idx} < 6'(N_REQ));
    owner_req_s = bus.req_i[last_r];
    others_s    = |(bus.req_i & ~(ONE_HOT0 << last_r));
    owner_pat_s = bus.pat_i[int'(last_r)*LED_W +: LED_W];
  end

  // Next-state, grant, LED and slice logic of the arbiter FSM.
  always_comb begin
    state_nxt_s = state_r;
    gnt_nxt_s   = gnt_r;
    led_nxt_s   = led_r;
    busy_nxt_s  = busy_r;
    last_nxt_s  = last_r;
    slice_nxt_s = slice_r;
    case (state_r)
      ST_IDLE: begin
        gnt_nxt_s   = '0;
        led_nxt_s   = '0;
        busy_nxt_s  = 1'b0;
        slice_nxt_s = '0;
        if (|bus.req_i) begin
          state_nxt_s = ST_ARB;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ARB: begin
        // LEDs stay dark for the grant edge; the pattern appears one edge later.
        led_nxt_s   = '0;
        slice_nxt_s = '0;
        if (pick_ok_s) begin
          state_nxt_s = ST_OWN;
          gnt_nxt_s   = ONE_HOT0 << pick_s.idx[IDX_W-1:0];
          last_nxt_s  = pick_s.idx[IDX_W-1:0];
          busy_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
          gnt_nxt_s   = '0;
          busy_nxt_s  = 1'b0;
        end
      end
      ST_OWN: begin
        if (!owner_req_s) begin
          // Owner let go: takes priority over slice expiry.
          gnt_nxt_s  = '0;
          led_nxt_s  = '0;
          busy_nxt_s = 1'b0;
          if (others_s) begin
            state_nxt_s = ST_ARB;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else if ((slice_r == SLICE_MAX) && others_s) begin
          gnt_nxt_s   = '0;
          led_nxt_s   = '0;
          busy_nxt_s  = 1'b0;
          state_nxt_s = ST_ARB;
        end else begin
          led_nxt_s = owner_pat_s;
          if (tick_s && (slice_r != SLICE_MAX)) begin
            slice_nxt_s = slice_r + SL_W'(1'b1);
          end else begin
            slice_nxt_s = slice_r;
          end
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        gnt_nxt_s   = '0;
        led_nxt_s   = '0;
        busy_nxt_s  = 1'b0;
        slice_nxt_s = '0;
      end
    endcase
  end

  // Arbiter state and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
      gnt_r   <= '0;
      led_r   <= '0;
      busy_r  <= 1'b0;
      last_r  <= IDX_W'(N_REQ - 1);
      slice_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      gnt_r   <= gnt_nxt_s;
      led_r   <= led_nxt_s;
      busy_r  <= busy_nxt_s;
      last_r  <= last_nxt_s;
      slice_r <= slice_nxt_s;
    end
  end

  assign bus.gnt_o  = gnt_r;
  assign bus.led_o  = led_r;
  assign bus.busy_o = busy_r;
  assign bus.tick_o = tick_s;
endmodule

// File: tb/tb_led_bank_arbiter.sv
// tb_led_bank_arbiter: directed scenarios plus randomized traffic, checked
// every cycle against a behavioural model of the arbitration rules.
module tb_led_bank_arbiter;
  localparam int N   = 4;
  localparam int LW  = 12;
  localparam int DW  = 4;
  localparam int HT  = 2;
  localparam int PER = 1 << DW;

  logic clk = 1'b0;
  logic rst_ni;
  always #5 clk = ~clk;

  led_bank_arbiter_if #(.N_REQ(N), .LED_W(LW)) bus ();

  led_bank_arbiter #(.N_REQ(N), .LED_W(LW), .DIV_W(DW), .HOLD_TICKS(HT)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  led_bank_arbiter_chk #(.N_REQ(N)) chk (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .gnt    (bus.gnt_o),
    .busy   (bus.busy_o)
  );

  int checks = 0;
  int failures = 0;
  int edge_no = 0;
  int first_tick_edge = -1;

  // Model: owner index (-1 none), pending arbitration, ticks seen while owning.
  int            m_edges, m_owner, m_last, m_ticks;
  bit            m_wait, m_tick;
  logic [LW-1:0] m_led;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_no);
    end
  endtask

  function automatic void model_reset();
    m_edges = 0; m_owner = -1; m_last = N - 1; m_ticks = 0;
    m_wait = 1'b0; m_tick = 1'b0; m_led = '0;
  endfunction

  function automatic void model_edge(input logic [N-1:0] req, input logic [N*LW-1:0] pat);
    bit others;
    bit tick_now;
    tick_now = m_tick;
    m_edges++;
    m_tick = ((m_edges % PER) == 0);
    m_led = '0;
    if (m_owner >= 0) begin
      others = 1'b0;
      for (int s = 0; s < N; s++) if (s != m_owner && req[s]) others = 1'b1;
      if (!req[m_owner] || (m_ticks >= HT && others)) begin
        m_owner = -1;
        m_wait  = others;
      end else begin
        m_led = pat[m_owner*LW +: LW];
        if (tick_now) m_ticks++;
      end
    end else if (m_wait) begin
      m_wait = 1'b0;
      for (int i = 1; i <= N; i++) begin
        int c;
        c = (m_last + i) % N;
        if (m_owner < 0 && req[c]) begin
          m_owner = c; m_last = c; m_ticks = 0;
        end
      end
    end else begin
      m_wait = (req != '0);
    end
  endfunction

  function automatic logic [N-1:0] m_gnt();
    return (m_owner >= 0) ? (N'(1) << m_owner) : '0;
  endfunction

  task automatic compare_all();
    check("gnt", bus.gnt_o, m_gnt());
    check("led", bus.led_o, m_led);
    check("tick", bus.tick_o, m_tick);
    check("busy", bus.busy_o, (m_owner >= 0));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge(bus.req_i, bus.pat_i);
    edge_no++;
    #1;
    if (bus.tick_o && first_tick_edge < 0) first_tick_edge = edge_no;
    compare_all();
  endtask

  // Async reset asserted between edges, checked before any clock edge.
  task automatic mid_reset();
    #2;
    rst_ni = 1'b0;
    model_reset();
    #1;
    check("rst_gnt", bus.gnt_o, 4'b0000);
    check("rst_led", bus.led_o, 12'h000);
    check("rst_busy", bus.busy_o, 1'b0);
    @(negedge clk);
    #2;
    rst_ni = 1'b1;
    model_reset();
    edge_no = 0;
    first_tick_edge = -1;
    compare_all();
  endtask

  function automatic int gnt_idx(input logic [N-1:0] g);
    for (int s = 0; s < N; s++) if (g[s]) return s;
    return -1;
  endfunction

  initial begin
    int order[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] prev_g;

    rst_ni = 1'b0;
    bus.req_i = '0;
    bus.pat_i = '0;
    model_reset();
    #1;
    compare_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    rst_ni = 1'b1;
    model_reset();

    // Single request on source 2.
    bus.req_i = 4'b0100;
    bus.pat_i[2*LW +: LW] = 12'hA5A;
    cycle();
    check("t2_arb_gap", bus.gnt_o, 4'b0000);
    cycle();
    check("t2_gnt", bus.gnt_o, 4'b0100);
    check("t2_led_lat", bus.led_o, 12'h000);
    cycle();
    check("t2_led", bus.led_o, 12'hA5A);
    repeat (60) cycle();
    check("t2_hold", bus.gnt_o, 4'b0100);
    check("t1_first_tick", first_tick_edge, 16);

    // Preemption of owner 2 by source 0.
    bus.req_i = 4'b0000;
    repeat (3) cycle();
    bus.req_i = 4'b0100;
    repeat (2) cycle();
    check("t3_gnt2", bus.gnt_o, 4'b0100);
    bus.req_i = 4'b0101;
    for (int i = 0; i < 80 && bus.gnt_o == 4'b0100; i++) cycle();
    check("t3_gap_gnt", bus.gnt_o, 4'b0000);
    check("t3_gap_led", bus.led_o, 12'h000);
    cycle();
    check("t3_new", bus.gnt_o, 4'b0001);

    // Reset mid-OWN, then round-robin with everybody requesting.
    mid_reset();
    bus.req_i = 4'b1111;
    prev_g = '0;
    for (int i = 0; i < 400 && order.size() < 5; i++) begin
      cycle();
      if (bus.gnt_o != '0 && prev_g == '0) order.push_back(gnt_idx(bus.gnt_o));
      prev_g = bus.gnt_o;
    end
    for (int i = 0; i < 5; i++)
      check("t4_order", (order.size() > i) ? order[i] : -1, exp_order[i]);
    check("t1_first_tick_again", first_tick_edge, 16);

    // Owner drops on the very cycle its slice expires.
    mid_reset();
    bus.req_i = 4'b0011;
    for (int i = 0; i < 200 && !(m_owner == 0 && m_ticks >= HT); i++) cycle();
    bus.req_i = 4'b1010;
    cycle();
    check("t5_gap", bus.gnt_o, 4'b0000);
    cycle();
    check("t5_next", bus.gnt_o, 4'b0010);

    // Live pattern tracking on owner 1.
    bus.pat_i[1*LW +: LW] = 12'h00F;
    cycle();
    check("t6_led_a", bus.led_o, 12'h00F);
    bus.pat_i[1*LW +: LW] = 12'hF00;
    cycle();
    check("t6_led_b", bus.led_o, 12'hF00);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bus.pat_i = 48'({$urandom(), $urandom()});
      if ($urandom_range(5) == 0) bus.req_i[$urandom_range(N - 1)] ^= 1'b1;
      if (i == 1500) mid_reset();
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
